// File: rtl/sb_pkg.sv
// Shared types and helpers for the register scoreboard.
// Default widths match the integer pipeline; the top-level parameters may override them.
package sb_pkg;

  localparam int AW        = 5;
  localparam int TAG_W_DEF = 2;
  localparam int XLEN_DEF  = 32;

  typedef logic [AW-1:0]        reg_addr_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [XLEN_DEF-1:0]  xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Largest in-flight count a tag width can disambiguate.
  function automatic int unsigned inflight_limit(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/sb_read_port.sv
// One source-operand resolver: picks zero, RF data or a tag-matched forward.
// Forward ports are prioritised by index, so index 0 (youngest) wins.
module sb_read_port
  import sb_pkg::*;
#(
  parameter int NUM_FWD   = 3,
  parameter int TAG_WIDTH = 2,
  parameter int XLEN      = 32
) (
  input  logic                     rd_en,
  input  reg_addr_t                rd_addr,
  input  logic                     dirty,
  input  logic [TAG_WIDTH-1:0]     tag,
  input  logic [XLEN-1:0]          rf_data,
  input  logic [NUM_FWD-1:0]       fwd_mask,
  input  logic [NUM_FWD-1:0]       fwd_en,
  input  logic [NUM_FWD*AW-1:0]    fwd_addr,
  input  logic [NUM_FWD*TAG_WIDTH-1:0] fwd_tag,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]          data,
  output logic                     valid
);

  logic [NUM_FWD-1:0] hit;

  always_comb begin
    hit = '0;
    for (int f = 0; f < NUM_FWD; f++) begin
      hit[f] = rd_en & fwd_en[f] & fwd_mask[f]
             & (fwd_addr[f*AW +: AW] == rd_addr)
             & (fwd_tag[f*TAG_WIDTH +: TAG_WIDTH] == tag);
    end
  end

  always_comb begin
    data  = '0;
    valid = 1'b0;
    if (!rd_en) begin
      valid = 1'b0;
    end else if (rd_addr == REG_ZERO) begin
      valid = 1'b1;
    end else if (!dirty) begin
      valid = 1'b1;
      data  = rf_data;
    end else begin
      valid = |hit;
      // Walk downwards so the lowest-index hit is the last write.
      for (int f = NUM_FWD - 1; f >= 0; f--) begin
        if (hit[f]) data = fwd_data[f*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/score_board_tracked.sv
// Register scoreboard: per-register dirty/tag/in-flight tracking plus operand resolution.
// Issue handshake: an issue is taken on a rising edge where iss_en & iss_rdy; iss_rdy never depends on iss_en.
module score_board_tracked
  import sb_pkg::*;
#(
  parameter int NUM_RD    = 3,
  parameter int NUM_FWD   = 3,
  parameter int TAG_WIDTH = 2,
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter logic [NUM_RD*NUM_FWD-1:0] FWD_MASK = 9'h1FF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          iss_en,
  input  reg_addr_t                     iss_addr,
  output logic                          iss_rdy,
  output logic [TAG_WIDTH-1:0]          iss_tag,
  input  logic                          wb_en,
  input  reg_addr_t                     wb_addr,
  input  logic [TAG_WIDTH-1:0]          wb_tag,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*AW-1:0]          rd_addr,
  output logic [NUM_RD*XLEN-1:0]        rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic [NUM_RD-1:0]             rf_rd_en,
  output logic [NUM_RD*AW-1:0]          rf_rd_addr,
  input  logic [NUM_RD*XLEN-1:0]        rf_rd_data,
  input  logic [NUM_FWD-1:0]            fwd_en,
  input  logic [NUM_FWD*AW-1:0]         fwd_addr,
  input  logic [NUM_FWD*TAG_WIDTH-1:0]  fwd_tag,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data
);

  localparam logic [TAG_WIDTH-1:0] CNT_MAX = TAG_WIDTH'(inflight_limit(TAG_WIDTH));

  // Entry 0 is only ever reset, so it stays a constant zero.
  logic                 dirty_q [NREG];
  logic [TAG_WIDTH-1:0] tag_q   [NREG];
  logic [TAG_WIDTH-1:0] cnt_q   [NREG];

  logic iss_fire;

  assign iss_tag  = (iss_addr == REG_ZERO) ? '0 : tag_q[iss_addr] + 1'b1;
  assign iss_rdy  = !flush && ((iss_addr == REG_ZERO) || (cnt_q[iss_addr] != CNT_MAX));
  assign iss_fire = iss_en && iss_rdy && (iss_addr != REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_fire && iss_addr == AW'(i)) begin
          // A same-cycle writeback cancels the count increment.
          dirty_q[i] <= 1'b1;
          tag_q[i]   <= iss_tag;
          if (!(wb_en && wb_addr == AW'(i))) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (wb_en && wb_addr == AW'(i)) begin
          if (cnt_q[i] != '0)      cnt_q[i]   <= cnt_q[i] - 1'b1;
          if (wb_tag == tag_q[i])  dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rf_rd_en   = rd_en;
  assign rf_rd_addr = rd_addr;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    reg_addr_t addr;
    assign addr = rd_addr[r*AW +: AW];

    sb_read_port #(
      .NUM_FWD   (NUM_FWD),
      .TAG_WIDTH (TAG_WIDTH),
      .XLEN      (XLEN)
    ) u_port (
      .rd_en    (rd_en[r]),
      .rd_addr  (addr),
      .dirty    (dirty_q[addr]),
      .tag      (tag_q[addr]),
      .rf_data  (rf_rd_data[r*XLEN +: XLEN]),
      .fwd_mask (FWD_MASK[r*NUM_FWD +: NUM_FWD]),
      .fwd_en   (fwd_en),
      .fwd_addr (fwd_addr),
      .fwd_tag  (fwd_tag),
      .fwd_data (fwd_data),
      .data     (rd_data[r*XLEN +: XLEN]),
      .valid    (rd_valid[r])
    );
  end

  // A writeback with nothing in flight means the pipeline lost track of a tag.
  wb_underflow_a: assert property (@(posedge clk) disable iff (rst)
    (wb_en && wb_addr != REG_ZERO && !flush) |-> (cnt_q[wb_addr] != '0));

endmodule

// File: tb/tb_score_board_tracked.sv
// Directed bench for score_board_tracked with hand-computed expectations.
module tb_score_board_tracked;

  localparam int NUM_RD  = 3;
  localparam int NUM_FWD = 3;
  localparam int TW      = 2;
  localparam int XLEN    = 32;
  localparam int AW      = 5;
  // Port 2 may only use fwd1; ports 0 and 1 use every forward port.
  localparam logic [8:0] MASK = 9'h0BF;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      iss_en;
  logic [AW-1:0]             iss_addr;
  logic                      iss_rdy;
  logic [TW-1:0]             iss_tag;
  logic                      wb_en;
  logic [AW-1:0]             wb_addr;
  logic [TW-1:0]             wb_tag;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_RD*AW-1:0]      rd_addr;
  logic [NUM_RD*XLEN-1:0]    rd_data;
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_RD-1:0]         rf_rd_en;
  logic [NUM_RD*AW-1:0]      rf_rd_addr;
  logic [NUM_RD*XLEN-1:0]    rf_rd_data;
  logic [NUM_FWD-1:0]        fwd_en;
  logic [NUM_FWD*AW-1:0]     fwd_addr;
  logic [NUM_FWD*TW-1:0]     fwd_tag;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  score_board_tracked #(
    .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .TAG_WIDTH(TW), .XLEN(XLEN), .NREG(32), .FWD_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy), .iss_tag(iss_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_tag(fwd_tag), .fwd_data(fwd_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; iss_en = 1'b0; iss_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_tag = '0;
    rd_en = '0; rd_addr = '0; rf_rd_data = '0;
    fwd_en = '0; fwd_addr = '0; fwd_tag = '0; fwd_data = '0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = a;
    rf_rd_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_fwd(input int f, input logic en, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [XLEN-1:0] d);
    fwd_en[f] = en;
    fwd_addr[f*AW +: AW] = a;
    fwd_tag[f*TW +: TW] = t;
    fwd_data[f*XLEN +: XLEN] = d;
  endtask

  // Issue one instruction; the expected tag comes from the scoreboard queue.
  task automatic issue(input logic [AW-1:0] a);
    logic [XLEN-1:0] e;
    iss_en = 1'b1; iss_addr = a;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL issue_q: got empty queue expected a tag");
    end else begin
      e = exp_q.pop_front();
      check("issue_tag", XLEN'(iss_tag), e);
    end
    check("issue_rdy", XLEN'(iss_rdy), 1);
    step();
    iss_en = 1'b0;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [TW-1:0] t);
    wb_en = 1'b1; wb_addr = a; wb_tag = t;
    step();
    wb_en = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] data_of(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    step();

    // 1: clean read, first issue, stall after issue
    set_rd(0, 1'b1, 5'd5, 32'h1234);
    iss_addr = 5'd5;
    #1;
    check("rst_valid", XLEN'(rd_valid[0]), 1);
    check("rst_data", data_of(0), 32'h1234);
    check("rst_rdy", XLEN'(iss_rdy), 1);
    check("rst_rf_en", XLEN'(rf_rd_en), 32'h1);
    check("rst_rf_addr", XLEN'(rf_rd_addr[4:0]), 5);
    set_rd(1, 1'b1, 5'd0, 32'hFFFF);
    #1;
    check("x0_read", data_of(1), 0);
    check("x0_valid", XLEN'(rd_valid[1]), 1);
    set_rd(1, 1'b0, 5'd0, 0);
    #1;
    check("rd_dis", XLEN'(rd_valid[1]), 0);
    exp_q.push_back(1);
    issue(5'd5);
    #1;
    check("x5_stall", XLEN'(rd_valid[0]), 0);
    check("x5_stall_d", data_of(0), 0);

    // 2: forward priority and tag match
    set_fwd(0, 1'b1, 5'd5, 2'd1, 32'hAA);
    set_fwd(1, 1'b1, 5'd5, 2'd1, 32'hBB);
    #1;
    check("fwd_pri_d", data_of(0), 32'hAA);
    check("fwd_pri_v", XLEN'(rd_valid[0]), 1);
    set_fwd(0, 1'b0, 5'd5, 2'd1, 32'hAA);
    #1;
    check("fwd1_d", data_of(0), 32'hBB);
    set_fwd(1, 1'b0, 0, 0, 0);
    set_fwd(2, 1'b1, 5'd5, 2'd2, 32'hCC);
    #1;
    check("fwd_badtag", XLEN'(rd_valid[0]), 0);
    set_fwd(2, 1'b0, 0, 0, 0);
    wb(5'd5, 2'd1);
    #1;
    check("x5_clean_v", XLEN'(rd_valid[0]), 1);
    check("x5_clean_d", data_of(0), 32'h1234);

    // 3: two in flight on x7, older completion keeps it dirty
    exp_q.push_back(1); exp_q.push_back(2);
    issue(5'd7);
    issue(5'd7);
    set_rd(1, 1'b1, 5'd7, 32'h7777);
    set_fwd(0, 1'b1, 5'd7, 2'd1, 32'h55);
    #1;
    check("x7_oldtag", XLEN'(rd_valid[1]), 0);
    set_fwd(0, 1'b1, 5'd7, 2'd2, 32'h66);
    #1;
    check("x7_newtag_v", XLEN'(rd_valid[1]), 1);
    check("x7_newtag_d", data_of(1), 32'h66);
    set_fwd(0, 1'b0, 0, 0, 0);
    wb(5'd7, 2'd1);
    #1;
    check("x7_still_dirty", XLEN'(rd_valid[1]), 0);
    wb(5'd7, 2'd2);
    #1;
    check("x7_clean", XLEN'(rd_valid[1]), 1);
    check("x7_clean_d", data_of(1), 32'h7777);
    set_rd(0, 1'b0, 0, 0); set_rd(1, 1'b0, 0, 0);

    // 4: in-flight limit, wrap, same-cycle issue+writeback
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    issue(5'd3); issue(5'd3); issue(5'd3);
    iss_addr = 5'd3; #1;
    check("x3_full", XLEN'(iss_rdy), 0);
    iss_addr = 5'd4; #1;
    check("x4_rdy", XLEN'(iss_rdy), 1);
    check("x4_tag", XLEN'(iss_tag), 1);
    iss_addr = 5'd0; #1;
    check("x0_rdy", XLEN'(iss_rdy), 1);
    check("x0_tag", XLEN'(iss_tag), 0);
    wb(5'd3, 2'd1);
    exp_q.push_back(0);
    issue(5'd3);
    iss_addr = 5'd3; #1;
    check("x3_full2", XLEN'(iss_rdy), 0);
    exp_q.push_back(1);
    issue(5'd4);
    iss_en = 1'b1; iss_addr = 5'd4;
    wb_en = 1'b1; wb_addr = 5'd4; wb_tag = 2'd1;
    #1;
    check("iw_tag", XLEN'(iss_tag), 2);
    step();
    iss_en = 1'b0; wb_en = 1'b0;
    set_rd(0, 1'b1, 5'd4, 32'h4444);
    set_fwd(0, 1'b1, 5'd4, 2'd1, 32'h41);
    #1;
    check("iw_dirty", XLEN'(rd_valid[0]), 0);
    set_fwd(0, 1'b1, 5'd4, 2'd2, 32'h42);
    #1;
    check("iw_fwd", data_of(0), 32'h42);
    set_fwd(0, 1'b0, 0, 0, 0);
    wb(5'd4, 2'd2);
    iss_addr = 5'd4; #1;
    check("x4_clean", XLEN'(rd_valid[0]), 1);
    check("x4_next_tag", XLEN'(iss_tag), 3);
    set_rd(0, 1'b0, 0, 0);

    // 5: forward mask on port 2
    exp_q.push_back(1);
    issue(5'd9);
    for (int p = 0; p < NUM_RD; p++) set_rd(p, 1'b1, 5'd9, 32'h9000 + p);
    set_fwd(0, 1'b1, 5'd9, 2'd1, 32'h99);
    #1;
    check("mask_v", XLEN'(rd_valid), 32'h3);
    check("mask_d0", data_of(0), 32'h99);
    check("mask_d1", data_of(1), 32'h99);
    check("mask_d2", data_of(2), 0);
    set_fwd(1, 1'b1, 5'd9, 2'd1, 32'h77);
    #1;
    check("mask_v2", XLEN'(rd_valid), 32'h7);
    check("mask_p2d", data_of(2), 32'h77);
    check("mask_p0d", data_of(0), 32'h99);
    set_fwd(0, 1'b0, 0, 0, 0); set_fwd(1, 1'b0, 0, 0, 0);

    // 6: flush with x3, x9, x10, x11 dirty; then async reset mid-cycle
    exp_q.push_back(1); exp_q.push_back(1);
    issue(5'd10);
    issue(5'd11);
    set_rd(0, 1'b1, 5'd3, 32'h3333);
    set_rd(1, 1'b1, 5'd10, 32'hA0A0);
    set_rd(2, 1'b1, 5'd11, 32'hB0B0);
    #1;
    check("pre_flush_v", XLEN'(rd_valid), 0);
    flush = 1'b1; iss_addr = 5'd10; #1;
    check("flush_rdy", XLEN'(iss_rdy), 0);
    step();
    flush = 1'b0;
    iss_addr = 5'd3;
    #1;
    check("post_flush_v", XLEN'(rd_valid), 32'h7);
    check("post_flush_d0", data_of(0), 32'h3333);
    check("post_flush_rdy", XLEN'(iss_rdy), 1);
    check("post_flush_tag", XLEN'(iss_tag), 1);
    set_rd(1, 1'b1, 5'd9, 32'h9999);
    #1;
    check("x9_flushed", data_of(1), 32'h9999);

    exp_q.push_back(1);
    issue(5'd12);
    set_rd(0, 1'b1, 5'd12, 32'hC0C0);
    iss_en = 1'b1; iss_addr = 5'd12;
    #1;
    check("x12_dirty", XLEN'(rd_valid[0]), 0);
    check("x12_tag2", XLEN'(iss_tag), 2);
    rst = 1'b1;
    #1;
    check("arst_valid", XLEN'(rd_valid[0]), 1);
    check("arst_data", data_of(0), 32'hC0C0);
    check("arst_tag", XLEN'(iss_tag), 1);
    idle();
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
